// File: rtl/palette_pkg.sv
// palette_pkg: default 16-colour palette, channel scaling and write-sequencer states.
package palette_pkg;

    typedef enum logic [1:0] {
        IDLE_R = 2'd0,
        HAVE_R = 2'd1,
        HAVE_G = 2'd2
    } seq_state_e;

    // 8-bit-per-channel RGB, CGA ordering; entry 15 is full white
    localparam logic [23:0] DEFAULT_PAL [16] = '{
        24'h000000, 24'h0000AA, 24'h00AA00, 24'h00AAAA,
        24'hAA0000, 24'hAA00AA, 24'hAA5500, 24'hAAAAAA,
        24'h555555, 24'h5555FF, 24'h55FF55, 24'h55FFFF,
        24'hFF5555, 24'hFF55FF, 24'hFFFF55, 24'hFFFFFF
    };

    function automatic logic [7:0] scale_ch(input logic [7:0] c, input int w);
        return c >> (8 - w);
    endfunction

endpackage

// File: rtl/palette_seq.sv
// palette_seq: CPU write/read sequencer and shared entry pointer.
// Readback phase logic exists only when PALETTE_READBACK_EN is defined.
module palette_seq import palette_pkg::*; #(
    parameter int ENTRIES = 16,
    parameter int CH_W    = 6,
    localparam int IDX_W  = $clog2(ENTRIES)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                idx_we,
    input  logic                dat_we,
    input  logic                dat_rd,
    input  logic [7:0]          cpu_d,
`ifdef PALETTE_READBACK_EN
    output logic                rd_en,
    output logic [1:0]          rd_ch,
`endif
    output logic                commit,
    output logic [3*CH_W-1:0]   wdata,
    output logic [IDX_W-1:0]    ptr
);

    seq_state_e       state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [CH_W-1:0]  r_q, r_d, g_q, g_d;
    logic             unused_d;

    assign unused_d = ^cpu_d;

`ifdef PALETTE_READBACK_EN
    logic [1:0] rph_q, rph_d;
`else
    logic unused_rd;
    assign unused_rd = dat_rd;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        r_d     = r_q;
        g_d     = g_q;
        commit  = 1'b0;
`ifdef PALETTE_READBACK_EN
        rph_d   = rph_q;
        rd_en   = 1'b0;
`endif
        if (idx_we) begin
            ptr_d   = cpu_d[IDX_W-1:0];
            state_d = IDLE_R;
`ifdef PALETTE_READBACK_EN
            rph_d   = 2'd0;
`endif
        end else if (dat_we) begin
            if (state_q == IDLE_R) begin
                r_d     = cpu_d[CH_W-1:0];
                state_d = HAVE_R;
            end else if (state_q == HAVE_R) begin
                g_d     = cpu_d[CH_W-1:0];
                state_d = HAVE_G;
            end else begin
                commit  = 1'b1;
                ptr_d   = ptr_q + 1'b1;
                state_d = IDLE_R;
            end
`ifdef PALETTE_READBACK_EN
        end else if (dat_rd) begin
            rd_en = 1'b1;
            rph_d = rph_q == 2'd2 ? 2'd0 : rph_q + 2'd1;
            ptr_d = rph_q == 2'd2 ? ptr_q + 1'b1 : ptr_q;
`endif
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE_R;
            ptr_q   <= '0;
            r_q     <= '0;
            g_q     <= '0;
`ifdef PALETTE_READBACK_EN
            rph_q   <= 2'd0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            r_q     <= r_d;
            g_q     <= g_d;
`ifdef PALETTE_READBACK_EN
            rph_q   <= rph_d;
`endif
        end
    end

    assign wdata = {r_q, g_q, cpu_d[CH_W-1:0]};
    assign ptr   = ptr_q;
`ifdef PALETTE_READBACK_EN
    assign rd_ch = rph_q;
`endif

endmodule

// File: rtl/palette_lut.sv
// palette_lut: palette LUT with 2-stage pixel pipeline and CPU write port.
// Define PALETTE_READBACK_EN to enable CPU readback through dat_rd/cpu_q.
module palette_lut import palette_pkg::*; #(
    parameter int ENTRIES = 16,
    parameter int CH_W    = 6,
    localparam int IDX_W  = $clog2(ENTRIES)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               ce_pix,
    input  logic               pixel,
    input  logic [IDX_W-1:0]   color,
    input  logic               hsync,
    input  logic               vsync,
    output logic               hsync_o,
    output logic               vsync_o,
    output logic [3*CH_W-1:0]  rgb,
    input  logic               idx_we,
    input  logic               dat_we,
    input  logic               dat_rd,
    input  logic [7:0]         cpu_d,
    output logic [7:0]         cpu_q
);

    function automatic logic [3*CH_W-1:0] def_entry(input int i);
        logic [23:0] p;
        logic [7:0]  r, g, b;
        p = DEFAULT_PAL[4'(i)];
        r = scale_ch(p[23:16], CH_W);
        g = scale_ch(p[15:8], CH_W);
        b = scale_ch(p[7:0], CH_W);
        return {CH_W'(r), CH_W'(g), CH_W'(b)};
    endfunction

    logic [3*CH_W-1:0] lut_q [ENTRIES];
    logic [3*CH_W-1:0] lut_d [ENTRIES];
    logic              commit;
    logic [3*CH_W-1:0] wdata;
    logic [IDX_W-1:0]  ptr;

    logic [IDX_W-1:0]  color_s1_q, color_s1_d;
    logic              pix_s1_q, pix_s1_d, hs_s1_q, hs_s1_d, vs_s1_q, vs_s1_d;
    logic [3*CH_W-1:0] rgb_q, rgb_d;
    logic              hs_o_q, hs_o_d, vs_o_q, vs_o_d;

`ifdef PALETTE_READBACK_EN
    logic              rd_en;
    logic [1:0]        rd_ch;
    logic [3*CH_W-1:0] rd_ent;
    logic [CH_W-1:0]   rd_val;
    logic [7:0]        cpu_q_q, cpu_q_d;
`endif

    palette_seq #(.ENTRIES(ENTRIES), .CH_W(CH_W)) u_seq (
        .clock  (clock),
        .reset  (reset),
        .idx_we (idx_we),
        .dat_we (dat_we),
        .dat_rd (dat_rd),
        .cpu_d  (cpu_d),
`ifdef PALETTE_READBACK_EN
        .rd_en  (rd_en),
        .rd_ch  (rd_ch),
`endif
        .commit (commit),
        .wdata  (wdata),
        .ptr    (ptr)
    );

    // Whole triple is written in one edge, so lookups never see a partial entry
    for (genvar e = 0; e < ENTRIES; e++) begin : g_lut
        assign lut_d[e] = (commit && ptr == IDX_W'(e)) ? wdata : lut_q[e];
        always_ff @(posedge clock or posedge reset) begin
            if (reset) lut_q[e] <= def_entry(e);
            else       lut_q[e] <= lut_d[e];
        end
    end

    always_comb begin
        color_s1_d = ce_pix ? color  : color_s1_q;
        pix_s1_d   = ce_pix ? pixel  : pix_s1_q;
        hs_s1_d    = ce_pix ? hsync  : hs_s1_q;
        vs_s1_d    = ce_pix ? vsync  : vs_s1_q;
        rgb_d      = ce_pix ? (pix_s1_q ? lut_q[color_s1_q] : '0) : rgb_q;
        hs_o_d     = ce_pix ? hs_s1_q : hs_o_q;
        vs_o_d     = ce_pix ? vs_s1_q : vs_o_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            color_s1_q <= '0;
            pix_s1_q   <= 1'b0;
            hs_s1_q    <= 1'b0;
            vs_s1_q    <= 1'b0;
            rgb_q      <= '0;
            hs_o_q     <= 1'b0;
            vs_o_q     <= 1'b0;
        end else begin
            color_s1_q <= color_s1_d;
            pix_s1_q   <= pix_s1_d;
            hs_s1_q    <= hs_s1_d;
            vs_s1_q    <= vs_s1_d;
            rgb_q      <= rgb_d;
            hs_o_q     <= hs_o_d;
            vs_o_q     <= vs_o_d;
        end
    end

    assign rgb     = rgb_q;
    assign hsync_o = hs_o_q;
    assign vsync_o = vs_o_q;

`ifdef PALETTE_READBACK_EN
    always_comb begin
        rd_ent  = lut_q[ptr];
        rd_val  = rd_ch == 2'd0 ? rd_ent[3*CH_W-1 -: CH_W] :
                  rd_ch == 2'd1 ? rd_ent[2*CH_W-1 -: CH_W] : rd_ent[CH_W-1:0];
        cpu_q_d = rd_en ? 8'(rd_val) : cpu_q_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) cpu_q_q <= 8'd0;
        else       cpu_q_q <= cpu_q_d;
    end

    assign cpu_q = cpu_q_q;
`else
    assign cpu_q = 8'd0;
`endif

endmodule

// File: tb/tb_palette_lut.sv
// tb_palette_lut: randomized and directed checks of palette_lut against a behavioural model.
module tb_palette_lut;

    logic        clock = 1'b0;
    logic        reset, ce_pix, pixel, hsync, vsync, idx_we, dat_we, dat_rd;
    logic [3:0]  color;
    logic [7:0]  cpu_d;
    logic        hsync_o, vsync_o;
    logic [17:0] rgb;
    logic [7:0]  cpu_q;

    palette_lut #(.ENTRIES(16), .CH_W(6)) dut (
        .clock(clock), .reset(reset), .ce_pix(ce_pix), .pixel(pixel), .color(color),
        .hsync(hsync), .vsync(vsync), .hsync_o(hsync_o), .vsync_o(vsync_o), .rgb(rgb),
        .idx_we(idx_we), .dat_we(dat_we), .dat_rd(dat_rd), .cpu_d(cpu_d), .cpu_q(cpu_q)
    );

    always #5 clock = ~clock;

    int vectors = 0;
    int miscompares = 0;

    logic [23:0] def24 [16];
    logic [17:0] pal [16];
    int          m_ptr, m_wph, m_rph;
    logic [5:0]  m_r, m_g;
    logic [3:0]  s1_col;
    logic        s1_pix, s1_hs, s1_vs, m_hs, m_vs;
    logic [17:0] m_rgb, held;
    logic [7:0]  m_cpuq;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [17:0] def6(input int i);
        logic [23:0] c;
        c = def24[i];
        return {c[23:18], c[15:10], c[7:2]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) pal[i] = def6(i);
        m_ptr = 0; m_wph = 0; m_rph = 0; m_r = 0; m_g = 0;
        s1_col = 0; s1_pix = 0; s1_hs = 0; s1_vs = 0;
        m_rgb = 0; m_hs = 0; m_vs = 0; m_cpuq = 0;
    endtask

    task automatic check_outs();
        check("rgb", 32'(rgb), 32'(m_rgb));
        check("hsync_o", 32'(hsync_o), 32'(m_hs));
        check("vsync_o", 32'(vsync_o), 32'(m_vs));
        check("cpu_q", 32'(cpu_q), 32'(m_cpuq));
    endtask

    // One clock: model advances with the inputs held across the edge, outputs checked at negedge
    task automatic tick();
        logic [17:0] e;
        @(posedge clock);
        if (ce_pix) begin
            m_rgb = s1_pix ? pal[s1_col] : 18'd0;
            m_hs = s1_hs; m_vs = s1_vs;
            s1_col = color; s1_pix = pixel; s1_hs = hsync; s1_vs = vsync;
        end
        if (idx_we) begin
            m_ptr = cpu_d % 16; m_wph = 0; m_rph = 0;
        end else if (dat_we) begin
            if (m_wph == 0) m_r = cpu_d[5:0];
            else if (m_wph == 1) m_g = cpu_d[5:0];
            else begin
                pal[m_ptr] = {m_r, m_g, cpu_d[5:0]};
                m_ptr = (m_ptr + 1) % 16;
            end
            m_wph = (m_wph + 1) % 3;
        end else if (dat_rd) begin
`ifdef PALETTE_READBACK_EN
            e = pal[m_ptr];
            m_cpuq = m_rph == 0 ? 8'(e[17:12]) : m_rph == 1 ? 8'(e[11:6]) : 8'(e[5:0]);
            if (m_rph == 2) m_ptr = (m_ptr + 1) % 16;
            m_rph = (m_rph + 1) % 3;
`endif
        end
        @(negedge clock);
        check_outs();
    endtask

    task automatic strobes_off();
        idx_we = 0; dat_we = 0; dat_rd = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        model_reset();
        check_outs();
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic cpu(input logic iw, input logic dw, input logic dr, input logic [7:0] d);
        idx_we = iw; dat_we = dw; dat_rd = dr; cpu_d = d;
        tick();
        strobes_off();
    endtask

    initial begin
        def24 = '{24'h000000, 24'h0000AA, 24'h00AA00, 24'h00AAAA,
                  24'hAA0000, 24'hAA00AA, 24'hAA5500, 24'hAAAAAA,
                  24'h555555, 24'h5555FF, 24'h55FF55, 24'h55FFFF,
                  24'hFF5555, 24'hFF55FF, 24'hFFFF55, 24'hFFFFFF};
        reset = 0; ce_pix = 0; pixel = 0; color = 0; hsync = 0; vsync = 0; cpu_d = 0;
        strobes_off();
        @(negedge clock);
        do_reset();
        check("rst_ptr", 32'(dut.u_seq.ptr_q), 0);
        check("rst_state", 32'(dut.u_seq.state_q), 0);

        // white after exactly two strobes, hsync aligned
        ce_pix = 1; pixel = 1; color = 15; hsync = 1;
        tick();
        check("white_lat1", 32'(rgb), 0);
        tick();
        check("white_lat2", 32'(rgb), 32'h3FFFF);
        check("hs_lat2", 32'(hsync_o), 1);
        hsync = 0;

        // entry 2 write, visible from the cycle after commit
        color = 2;
        cpu(1, 0, 0, 8'd2);
        cpu(0, 1, 0, 8'h3F);
        cpu(0, 1, 0, 8'h00);
        cpu(0, 1, 0, 8'h15);
        check("commit_old", 32'(rgb), 32'(def6(2)));
        check("ptr_after_e2", 32'(dut.u_seq.ptr_q), 3);
        tick();
        check("commit_new", 32'(rgb), 32'h3F015);

        // pointer wrap 15 -> 0 -> 1
        cpu(1, 0, 0, 8'd15);
        for (int i = 0; i < 6; i++) cpu(0, 1, 0, 8'($urandom_range(0, 255)));
        check("wrap_ptr", 32'(dut.u_seq.ptr_q), 1);
        color = 15; tick(); tick();
        color = 0;  tick(); tick();

        // reset mid-sequence discards partial triple
        cpu(1, 0, 0, 8'd2);
        cpu(0, 1, 0, 8'h11);
        cpu(0, 1, 0, 8'h22);
        do_reset();
        check("mid_rst_state", 32'(dut.u_seq.state_q), 0);
        ce_pix = 1; pixel = 1; color = 2;
        tick(); tick();
        check("mid_rst_e2", 32'(rgb), 32'(def6(2)));

        // idx_we beats dat_we; ce_pix low freezes the pixel outputs
        held = rgb;
        ce_pix = 0; color = 7; pixel = 0; hsync = 1; vsync = 1;
        cpu(1, 1, 0, 8'd5);
        check("idx_win_ptr", 32'(dut.u_seq.ptr_q), 5);
        check("idx_win_state", 32'(dut.u_seq.state_q), 0);
        check("ce0_hold", 32'(rgb), 32'(held));
        tick();
        check("ce0_hold_hs", 32'(hsync_o), 0);
        cpu(0, 1, 0, 8'h01); cpu(0, 1, 0, 8'h02); cpu(0, 1, 0, 8'h03);
        hsync = 0; vsync = 0;

`ifdef PALETTE_READBACK_EN
        cpu(1, 0, 0, 8'd4);
        cpu(0, 0, 1, 8'd0);
        check("rb_r", 32'(cpu_q), 32'(def6(4)) >> 12);
        cpu(0, 0, 1, 8'd0);
        check("rb_g", 32'(cpu_q), (32'(def6(4)) >> 6) & 32'h3F);
        cpu(0, 0, 1, 8'd0);
        check("rb_b", 32'(cpu_q), 32'(def6(4)) & 32'h3F);
        check("rb_ptr", 32'(dut.u_seq.ptr_q), 5);
`else
        cpu(0, 0, 1, 8'd0);
        check("no_rb_q", 32'(cpu_q), 0);
`endif

        // randomized traffic
        for (int n = 0; n < 800; n++) begin
            int r;
            ce_pix = $urandom_range(0, 3) != 0;
            pixel  = $urandom_range(0, 4) != 0;
            color  = 4'($urandom_range(0, 15));
            hsync  = 1'($urandom);
            vsync  = 1'($urandom);
            cpu_d  = 8'($urandom);
            r = $urandom_range(0, 15);
            idx_we = r == 0 || r == 7;
            dat_we = r inside {1, 2, 3, 4, 7, 8};
            dat_rd = r inside {5, 6, 8, 9};
            tick();
        end
        strobes_off();
        for (int c = 0; c < 16; c++) begin
            ce_pix = 1; pixel = 1; color = 4'(c);
            tick();
        end
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
